// File: rtl/apb_2_axil_bridge_if.sv
// apb_2_axil_bridge_if: APB4 request/response and AXI4-Lite channel bundle.
// slave is the bridge view; master is the APB-master / AXI-slave environment view.
interface apb_2_axil_bridge_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) ();
   logic                    psel, penable, pwrite;
   logic [ADDR_WIDTH-1:0]   paddr;
   logic [DATA_WIDTH-1:0]   pwdata;
   logic [DATA_WIDTH/8-1:0] pstrb;
   logic [2:0]              pprot;
   logic                    pready, pslverr;
   logic [DATA_WIDTH-1:0]   prdata;
   logic                    aw_valid, aw_ready;
   logic [ADDR_WIDTH-1:0]   aw_addr;
   logic [2:0]              aw_prot;
   logic                    w_valid, w_ready;
   logic [DATA_WIDTH-1:0]   w_data;
   logic [DATA_WIDTH/8-1:0] w_strb;
   logic                    b_valid, b_ready;
   logic [1:0]              b_resp;
   logic                    ar_valid, ar_ready;
   logic [ADDR_WIDTH-1:0]   ar_addr;
   logic [2:0]              ar_prot;
   logic                    r_valid, r_ready;
   logic [DATA_WIDTH-1:0]   r_data;
   logic [1:0]              r_resp;

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
      output pready, prdata, pslverr,
      output aw_valid, aw_addr, aw_prot, input aw_ready,
      output w_valid, w_data, w_strb, input w_ready,
      input  b_valid, b_resp, output b_ready,
      output ar_valid, ar_addr, ar_prot, input ar_ready,
      input  r_valid, r_data, r_resp, output r_ready
   );

   modport master (
      output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
      input  pready, prdata, pslverr,
      input  aw_valid, aw_addr, aw_prot, output aw_ready,
      input  w_valid, w_data, w_strb, output w_ready,
      output b_valid, b_resp, input b_ready,
      input  ar_valid, ar_addr, ar_prot, output ar_ready,
      output r_valid, r_data, r_resp, input r_ready
   );
endinterface

// File: rtl/apb_2_axil_bridge.sv
// apb_2_axil_bridge: APB4 slave to AXI4-Lite master bridge with address window decode.
// Define APB_2_AXIL_RESP_REG_EN to register the APB response through a RESP state.
module apb_2_axil_bridge #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] ADDR_BASE  = '0,
   parameter logic [ADDR_WIDTH-1:0] ADDR_SIZE  = '0
) (
   input  logic               clk_i,
   input  logic               arst_ni,
   apb_2_axil_bridge_if.slave bus
);
   typedef enum logic [2:0] {IDLE, WRITE, WAIT_B, READ, WAIT_R, RESP, ERR} state_t;
`ifdef APB_2_AXIL_RESP_REG_EN
   localparam state_t DONE_ST = RESP;
`else
   localparam state_t DONE_ST = IDLE;
`endif

   state_t                state, state_nxt;
   logic                  aw_done, w_done, in_win, access, unused_resp;
   logic [ADDR_WIDTH-1:0] offset;

   // unsigned wrap-around of the offset puts addresses below the base out of window
   assign offset      = bus.paddr - ADDR_BASE;
   assign in_win      = (ADDR_SIZE == '0) || (offset < ADDR_SIZE);
   assign access      = bus.psel && bus.penable;
   assign unused_resp = bus.b_resp[0] ^ bus.r_resp[0];

   assign bus.aw_addr  = bus.paddr;
   assign bus.ar_addr  = bus.paddr;
   assign bus.aw_prot  = bus.pprot;
   assign bus.ar_prot  = bus.pprot;
   assign bus.w_data   = bus.pwdata;
   assign bus.w_strb   = bus.pstrb;
   assign bus.aw_valid = (state == WRITE) && !aw_done;
   assign bus.w_valid  = (state == WRITE) && !w_done;
   assign bus.b_ready  = state == WAIT_B;
   assign bus.ar_valid = state == READ;
   assign bus.r_ready  = state == WAIT_R;

   always_ff @(posedge clk_i or negedge arst_ni)
      if (!arst_ni) begin
         state   <= IDLE;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         state   <= state_nxt;
         aw_done <= (state == WRITE) && (aw_done || bus.aw_ready);
         w_done  <= (state == WRITE) && (w_done || bus.w_ready);
      end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (access) state_nxt = !in_win ? ERR : bus.pwrite ? WRITE : READ;
         WRITE:   if ((aw_done || bus.aw_ready) && (w_done || bus.w_ready)) state_nxt = WAIT_B;
         WAIT_B:  if (bus.b_valid) state_nxt = DONE_ST;
         READ:    if (bus.ar_ready) state_nxt = WAIT_R;
         WAIT_R:  if (bus.r_valid) state_nxt = DONE_ST;
         default: state_nxt = IDLE;
      endcase
   end

`ifdef APB_2_AXIL_RESP_REG_EN
   logic                  err_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i or negedge arst_ni)
      if (!arst_ni) begin
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else if (state == WAIT_B && bus.b_valid) begin
         err_q   <= bus.b_resp[1];
         rdata_q <= '0;
      end else if (state == WAIT_R && bus.r_valid) begin
         err_q   <= bus.r_resp[1];
         rdata_q <= bus.r_data;
      end

   assign bus.pready  = (state == RESP) || (state == ERR);
   assign bus.prdata  = (state == RESP) ? rdata_q : '0;
   assign bus.pslverr = (state == ERR) || ((state == RESP) && err_q);
`else
   logic b_fire, r_fire;

   // response is passed straight through in the cycle the AXI slave answers
   assign b_fire      = (state == WAIT_B) && bus.b_valid;
   assign r_fire      = (state == WAIT_R) && bus.r_valid;
   assign bus.pready  = (state == ERR) || b_fire || r_fire;
   assign bus.prdata  = r_fire ? bus.r_data : '0;
   assign bus.pslverr = (state == ERR) || (b_fire && bus.b_resp[1]) || (r_fire && bus.r_resp[1]);
`endif
endmodule

// File: tb/tb_apb_2_axil_bridge.sv
// tb_apb_2_axil_bridge: vector table, hand sequences and random traffic against a latency/response model.
module tb_apb_2_axil_bridge;
`ifdef APB_2_AXIL_RESP_REG_EN
   localparam int REG = 1;
`else
   localparam int REG = 0;
`endif

   typedef struct {
      logic        wr, sel;
      logic [31:0] addr, data;
      logic [3:0]  strb;
      logic [31:0] rdata;
      logic [1:0]  resp;
      int          aw_d, w_d, b_d, ar_d, r_d;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   logic clk = 0, rst_n = 0;
   always #5 clk = ~clk;

   apb_2_axil_bridge_if #(32, 32) m_if ();
   apb_2_axil_bridge_if #(32, 32) w_if ();

   apb_2_axil_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk_i(clk), .arst_ni(rst_n), .bus(m_if));
   apb_2_axil_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ADDR_BASE(32'h1000), .ADDR_SIZE(32'h100)) dut_win (
      .clk_i(clk), .arst_ni(rst_n), .bus(w_if));

   logic        psel = 0, penable = 0, pwrite = 0, win = 0;
   logic [31:0] paddr = 0, pwdata = 0;
   logic [3:0]  pstrb = 0;
   logic [2:0]  pprot = 0;

   assign m_if.psel = psel && !win;
   assign w_if.psel = psel && win;
   assign m_if.penable = penable;  assign w_if.penable = penable;
   assign m_if.pwrite = pwrite;    assign w_if.pwrite = pwrite;
   assign m_if.paddr = paddr;      assign w_if.paddr = paddr;
   assign m_if.pwdata = pwdata;    assign w_if.pwdata = pwdata;
   assign m_if.pstrb = pstrb;      assign w_if.pstrb = pstrb;
   assign m_if.pprot = pprot;      assign w_if.pprot = pprot;

   // the windowed bridge sees an always-ready zero-wait slave
   assign w_if.aw_ready = 1'b1;
   assign w_if.w_ready = 1'b1;
   assign w_if.b_valid = 1'b1;
   assign w_if.b_resp = 2'b00;
   assign w_if.ar_ready = 1'b1;
   assign w_if.r_valid = 1'b1;
   assign w_if.r_data = 32'hCAFE_F00D;
   assign w_if.r_resp = 2'b00;

   wire        pready_o  = win ? w_if.pready : m_if.pready;
   wire        pslverr_o = win ? w_if.pslverr : m_if.pslverr;
   wire [31:0] prdata_o  = win ? w_if.prdata : m_if.prdata;

   int n_chk = 0, n_pass = 0, cyc = 0, t0 = 0, n_done = 0, n_pr = 0, n_winv = 0;
   int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   logic [31:0] s_rdata = 0;
   logic [1:0]  s_resp = 0;
   int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, b_iss = 0, r_iss = 0;
   int aw_wt = 0, w_wt = 0, ar_wt = 0, b_wt = 0, r_wt = 0;
   int c_aw = 0, c_w = 0, c_ar = 0, f_aw = -1, f_w = -1, f_b = -1, f_ar = -1, f_r = -1;
   bit p_b = 0, p_r = 0;
   logic [31:0] cap_aw = 0, cap_wd = 0, cap_ar = 0;
   logic [3:0]  cap_ws = 0;
   logic [2:0]  cap_awp = 0, cap_arp = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   initial forever @(posedge clk) cyc++;

   // AXI-Lite slave on the full-window bridge with per-channel wait counts
   initial begin
      m_if.aw_ready = 0; m_if.w_ready = 0; m_if.ar_ready = 0;
      m_if.b_valid = 0; m_if.b_resp = 0; m_if.r_valid = 0; m_if.r_data = 0; m_if.r_resp = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_if.aw_ready = 0; m_if.w_ready = 0; m_if.ar_ready = 0;
            m_if.b_valid = 0; m_if.r_valid = 0;
            p_b = 0; p_r = 0; aw_wt = 0; w_wt = 0; ar_wt = 0; b_wt = 0; r_wt = 0;
            b_iss = (n_aw > n_w) ? n_aw : n_w;
            r_iss = n_ar;
         end else begin
            if (p_b) m_if.b_valid = 0;
            if (p_r) m_if.r_valid = 0;
            if (!m_if.b_valid && n_aw > b_iss && n_w > b_iss) begin
               if (b_wt == b_dly) begin m_if.b_valid = 1; m_if.b_resp = s_resp; b_iss++; b_wt = 0; end
               else b_wt++;
            end
            if (!m_if.r_valid && n_ar > r_iss) begin
               if (r_wt == r_dly) begin
                  m_if.r_valid = 1; m_if.r_data = s_rdata; m_if.r_resp = s_resp; r_iss++; r_wt = 0;
               end else r_wt++;
            end
            m_if.aw_ready = m_if.aw_valid && aw_wt == aw_dly;
            aw_wt = m_if.aw_valid ? aw_wt + 1 : 0;
            m_if.w_ready = m_if.w_valid && w_wt == w_dly;
            w_wt = m_if.w_valid ? w_wt + 1 : 0;
            m_if.ar_ready = m_if.ar_valid && ar_wt == ar_dly;
            ar_wt = m_if.ar_valid ? ar_wt + 1 : 0;
            if (m_if.aw_valid && m_if.aw_ready) begin n_aw++; cap_aw = m_if.aw_addr; cap_awp = m_if.aw_prot; end
            if (m_if.w_valid && m_if.w_ready) begin n_w++; cap_wd = m_if.w_data; cap_ws = m_if.w_strb; end
            if (m_if.ar_valid && m_if.ar_ready) begin n_ar++; cap_ar = m_if.ar_addr; cap_arp = m_if.ar_prot; end
            p_b = m_if.b_valid && m_if.b_ready;
            p_r = m_if.r_valid && m_if.r_ready;
            n_b += int'(p_b);
            n_r += int'(p_r);
         end
      end
   end

   initial forever begin
      @(negedge clk); #2;
      if (rst_n) begin
         n_pr += int'(m_if.pready) + int'(w_if.pready);
         n_winv += int'(w_if.aw_valid | w_if.w_valid | w_if.ar_valid);
         if (m_if.aw_valid) begin c_aw++; if (f_aw < 0) f_aw = cyc; end
         if (m_if.w_valid) begin c_w++; if (f_w < 0) f_w = cyc; end
         if (m_if.ar_valid) begin c_ar++; if (f_ar < 0) f_ar = cyc; end
         if (m_if.b_valid && f_b < 0) f_b = cyc;
         if (m_if.r_valid && f_r < 0) f_r = cyc;
      end
   end

   function automatic bit in_win(input logic [31:0] a);
      return a >= 32'h1000 && a <= 32'h10FF;
   endfunction

   function automatic int max2(input int a, input int b);
      return a > b ? a : b;
   endfunction

   function automatic int exp_lat(input vec_t v);
      if (v.sel && !in_win(v.addr)) return 1;
      return v.wr ? 2 + max2(v.aw_d, v.w_d) + v.b_d + REG : 2 + v.ar_d + v.r_d + REG;
   endfunction

   task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic [2:0] p, input logic sel,
                       output logic [31:0] rd, output logic er, output int lat);
      bit got = 0;
      win = sel; psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = d; pstrb = s; pprot = p;
      c_aw = 0; c_w = 0; c_ar = 0; n_winv = 0;
      f_aw = -1; f_w = -1; f_b = -1; f_ar = -1; f_r = -1;
      @(posedge clk); #1;
      penable = 1; t0 = cyc;
      rd = 0; er = 0; lat = -1;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk); #2;
         if (pready_o) begin got = 1; lat = cyc - t0; rd = prdata_o; er = pslverr_o; end
      end
      chk("pready_arrives", got, 1);
      if (got) n_done++;
      @(posedge clk); #1;
      psel = 0; penable = 0;
   endtask

   task automatic run(input vec_t v);
      logic [31:0] rd;
      logic er;
      logic [2:0] prot;
      int lat, a0, w0, b0, ar0, r0;
      aw_dly = v.aw_d; w_dly = v.w_d; b_dly = v.b_d; ar_dly = v.ar_d; r_dly = v.r_d;
      s_rdata = v.rdata; s_resp = v.resp;
      prot = 3'($urandom_range(0, 7));
      a0 = n_aw; w0 = n_w; b0 = n_b; ar0 = n_ar; r0 = n_r;
      xfer(v.wr, v.addr, v.data, v.strb, prot, v.sel, rd, er, lat);
      chk("pslverr", er, v.exp_err);
      chk("prdata", rd, v.exp_rdata);
      chk("latency", lat, exp_lat(v));
      if (v.sel) chk("win_axi_valid_cycles", n_winv, in_win(v.addr) ? 1 : 0);
      else begin
         chk("axi_handshakes", (n_aw-a0)*10000 + (n_w-w0)*1000 + (n_b-b0)*100 + (n_ar-ar0)*10 + (n_r-r0),
             v.wr ? 11100 : 11);
         if (v.wr) begin
            chk("aw_addr_prot", {cap_awp, cap_aw}, {prot, v.addr});
            chk("w_data_strb", {cap_ws, cap_wd}, {v.strb, v.data});
            chk("aw_valid_cycles", c_aw, v.aw_d + 1);
            chk("w_valid_cycles", c_w, v.w_d + 1);
            chk("aw_w_valid_t", {f_aw - t0, f_w - t0}, {32'd1, 32'd1});
            chk("b_valid_t", f_b - t0, 2 + max2(v.aw_d, v.w_d) + v.b_d);
         end else begin
            chk("ar_addr_prot", {cap_arp, cap_ar}, {prot, v.addr});
            chk("ar_valid_cycles", c_ar, v.ar_d + 1);
            chk("ar_valid_t", f_ar - t0, 1);
            chk("r_valid_t", f_r - t0, 2 + v.ar_d + v.r_d);
         end
      end
   endtask

   vec_t tbl[11];
   vec_t v;
   bit seen;

   initial begin
      tbl[0]  = '{1, 0, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        2'b00, 0, 0, 0, 0, 0, 0, 32'h0};
      tbl[1]  = '{1, 0, 32'h14,   32'h0BADF00D, 4'h3, 32'h0,        2'b01, 3, 0, 0, 0, 0, 0, 32'h0};
      tbl[2]  = '{0, 0, 32'h20,   32'h0,        4'h0, 32'h12345678, 2'b10, 0, 0, 0, 0, 4, 1, 32'h12345678};
      tbl[3]  = '{0, 0, 32'h24,   32'h0,        4'h0, 32'hA5A5A5A5, 2'b11, 0, 0, 0, 2, 0, 1, 32'hA5A5A5A5};
      tbl[4]  = '{1, 0, 32'h28,   32'h11223344, 4'hC, 32'h0,        2'b10, 0, 2, 3, 0, 0, 1, 32'h0};
      tbl[5]  = '{0, 0, 32'h2C,   32'h0,        4'h0, 32'h0F0F0F0F, 2'b01, 0, 0, 0, 1, 2, 0, 32'h0F0F0F0F};
      tbl[6]  = '{0, 1, 32'h1100, 32'h0,        4'h0, 32'h0,        2'b00, 0, 0, 0, 0, 0, 1, 32'h0};
      tbl[7]  = '{1, 1, 32'h0FFC, 32'h1,        4'hF, 32'h0,        2'b00, 0, 0, 0, 0, 0, 1, 32'h0};
      tbl[8]  = '{0, 1, 32'h10FC, 32'h0,        4'h0, 32'h0,        2'b00, 0, 0, 0, 0, 0, 0, 32'hCAFEF00D};
      tbl[9]  = '{1, 1, 32'h1000, 32'h77,       4'h1, 32'h0,        2'b00, 0, 0, 0, 0, 0, 0, 32'h0};
      tbl[10] = '{0, 1, 32'h0,    32'h0,        4'h0, 32'h0,        2'b00, 0, 0, 0, 0, 0, 1, 32'h0};

      #12;
      chk("reset_ctrl", {m_if.pready, m_if.pslverr, m_if.aw_valid, m_if.w_valid, m_if.b_ready,
                         m_if.ar_valid, m_if.r_ready}, 0);
      chk("reset_prdata", m_if.prdata, 0);
      chk("reset_win_ctrl", {w_if.pready, w_if.pslverr, w_if.aw_valid, w_if.w_valid, w_if.ar_valid}, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++) run(tbl[i]);

      // reset while waiting for R
      s_rdata = 32'h9999_0000; s_resp = 0; ar_dly = 0; r_dly = 20;
      win = 0; psel = 1; penable = 0; pwrite = 0; paddr = 32'h30; pprot = 0;
      @(posedge clk); #1 penable = 1;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); #2; seen = m_if.r_ready; end
      chk("reach_wait_r", seen, 1);
      rst_n = 0;
      #1;
      chk("rst_async_r_ready", m_if.r_ready, 0);
      chk("rst_async_pready", m_if.pready, 0);
      psel = 0; penable = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      repeat (3) @(posedge clk);
      #1;
      v = '{0, 0, 32'h34, 32'h0, 4'h0, 32'h55AA55AA, 2'b00, 0, 0, 0, 0, 1, 0, 32'h55AA55AA};
      run(v);

      for (int i = 0; i < 28; i++) begin
         v.wr = 1'($urandom_range(0, 1));
         v.sel = (i % 4 == 3);
         v.data = $urandom; v.strb = 4'($urandom_range(0, 15));
         if (v.sel) begin
            v.addr = 32'h0F00 + ($urandom_range(0, 32'h200) & 32'hFFFC);
            v.rdata = 0; v.resp = 0;
            v.aw_d = 0; v.w_d = 0; v.b_d = 0; v.ar_d = 0; v.r_d = 0;
            v.exp_err = !in_win(v.addr);
            v.exp_rdata = (!v.wr && in_win(v.addr)) ? 32'hCAFEF00D : 32'h0;
         end else begin
            v.addr = $urandom & 32'hFFFC;
            v.rdata = $urandom; v.resp = 2'($urandom_range(0, 3));
            v.aw_d = $urandom_range(0, 3); v.w_d = $urandom_range(0, 3); v.b_d = $urandom_range(0, 3);
            v.ar_d = $urandom_range(0, 3); v.r_d = $urandom_range(0, 3);
            v.exp_err = v.resp >= 2;
            v.exp_rdata = v.wr ? 32'h0 : v.rdata;
         end
         run(v);
      end

      repeat (3) @(posedge clk);
      #1;
      chk("pready_cycles_total", n_pr, n_done);
      chk("b_vs_aw_total", n_b, n_aw);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish (checks %0d)", n_chk);
      $fatal(1);
   end
endmodule
